// File: rtl/morse_pkg.sv
// Shared types and default timing for the Morse letter front-end.
// Timing values are in Morse units; one unit is one clock.
package morse_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MARK = 2'd1,
        GAP  = 2'd2,
        ERR  = 2'd3
    } morse_state_e;

    localparam logic ELEM_DOT  = 1'b0;
    localparam logic ELEM_DASH = 1'b1;

    localparam int DEF_MAX_ELEM   = 6;
    localparam int DEF_DASH_LEN   = 3;
    localparam int DEF_LETTER_GAP = 3;
    localparam int DEF_WORD_GAP   = 7;

endpackage

// File: rtl/morse_letter_ctrl_if.sv
// Line input and letter/word/error outputs of the Morse letter controller.
// The master drives the line; the slave is the controller.
interface morse_letter_ctrl_if #(
    parameter int MAX_ELEM = 6
);
    localparam int LEN_W = $clog2(MAX_ELEM + 1);

    logic                in;
    logic                busy;
    logic                letter_valid;
    logic [LEN_W-1:0]    letter_len;
    logic [MAX_ELEM-1:0] letter_bits;
    logic                word_end;
    logic                err;

    modport master (
        output in,
        input  busy, letter_valid, letter_len, letter_bits, word_end, err
    );

    modport slave (
        input  in,
        output busy, letter_valid, letter_len, letter_bits, word_end, err
    );

endinterface

// File: rtl/morse_run_cnt.sv
// Saturating run-length counter: counts while inc is high, clears on clr.
// One instance tracks marks, another tracks spaces.
module morse_run_cnt #(
    parameter  int SAT = 4,
    localparam int W   = $clog2(SAT + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && cnt != W'(SAT)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/morse_letter_ctrl.sv
// Morse sequencer: classifies mark/space runs into dots, dashes and gaps,
// assembles letters and reports letter, word-end and error pulses.
module morse_letter_ctrl
    import morse_pkg::*;
#(
    parameter int MAX_ELEM   = DEF_MAX_ELEM,
    parameter int DASH_LEN   = DEF_DASH_LEN,
    parameter int LETTER_GAP = DEF_LETTER_GAP,
    parameter int WORD_GAP   = DEF_WORD_GAP
) (
    input logic              clk,
    input logic              rst,
    morse_letter_ctrl_if.slave bus
);

    localparam int LEN_W = $clog2(MAX_ELEM + 1);
    localparam int MW    = $clog2(DASH_LEN + 2);
    localparam int SW    = $clog2(WORD_GAP + 1);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_MARK = MARK;
    localparam logic [1:0] ST_GAP  = GAP;
    localparam logic [1:0] ST_ERR  = ERR;

    logic [MW-1:0]       mark_cnt;
    logic [SW-1:0]       space_cnt;
    logic [1:0]          state_reg, state_next;
    logic [LEN_W-1:0]    elem_cnt_reg, elem_cnt_next;
    logic [MAX_ELEM-1:0] bits_reg, bits_next;
    logic                word_open_reg, word_open_next;
    logic                append, buf_clr, elem_sym;
    logic                busy_reg, busy_next;
    logic                letter_valid_reg, letter_valid_next;
    logic [LEN_W-1:0]    letter_len_reg, letter_len_next;
    logic [MAX_ELEM-1:0] letter_bits_reg, letter_bits_next;
    logic                word_end_reg, word_end_next;
    logic                err_reg, err_next;

    // Both counters run in every state; the FSM only interprets them.
    morse_run_cnt #(.SAT(DASH_LEN + 1)) u_mark_cnt (
        .clk (clk),
        .rst (rst),
        .inc (bus.in),
        .clr (~bus.in),
        .cnt (mark_cnt)
    );

    morse_run_cnt #(.SAT(WORD_GAP)) u_space_cnt (
        .clk (clk),
        .rst (rst),
        .inc (~bus.in),
        .clr (bus.in),
        .cnt (space_cnt)
    );

    assign elem_sym = (mark_cnt == MW'(DASH_LEN)) ? ELEM_DASH : ELEM_DOT;

    always_comb begin
        state_next     = state_reg;
        word_open_next = word_open_reg;
        append         = 1'b0;
        buf_clr        = 1'b0;
        err_next       = 1'b0;
        word_end_next  = 1'b0;
        letter_valid_next = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (bus.in) begin
                    state_next = ST_MARK;
                end else if (word_open_reg && space_cnt == SW'(WORD_GAP - 1)) begin
                    word_end_next  = 1'b1;
                    word_open_next = 1'b0;
                end
            end
            ST_MARK: begin
                // Decisions use the count before this sample: "would reach" checks.
                if (bus.in) begin
                    if (mark_cnt == MW'(DASH_LEN)) begin
                        err_next   = 1'b1;
                        state_next = ST_ERR;
                        buf_clr    = 1'b1;
                    end
                end else if ((mark_cnt == MW'(1) || mark_cnt == MW'(DASH_LEN)) &&
                             elem_cnt_reg != LEN_W'(MAX_ELEM)) begin
                    append     = 1'b1;
                    state_next = ST_GAP;
                end else begin
                    err_next   = 1'b1;
                    state_next = ST_ERR;
                    buf_clr    = 1'b1;
                end
            end
            ST_GAP: begin
                if (bus.in) begin
                    state_next = ST_MARK;
                end else if (space_cnt == SW'(LETTER_GAP - 1)) begin
                    letter_valid_next = 1'b1;
                    word_open_next    = 1'b1;
                    buf_clr           = 1'b1;
                    state_next        = ST_IDLE;
                end
            end
            default: begin
                if (!bus.in && space_cnt == SW'(LETTER_GAP - 1)) begin
                    state_next = ST_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        elem_cnt_next = elem_cnt_reg;
        if (buf_clr) begin
            elem_cnt_next = '0;
        end else if (append) begin
            elem_cnt_next = elem_cnt_reg + 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < MAX_ELEM; gi++) begin : g_buf
            assign bits_next[gi] = buf_clr ? 1'b0 :
                                   (append && elem_cnt_reg == LEN_W'(gi)) ? elem_sym :
                                   bits_reg[gi];
        end
    endgenerate

    assign busy_next        = (state_next == ST_MARK) || (state_next == ST_GAP);
    assign letter_len_next  = letter_valid_next ? elem_cnt_reg : '0;
    assign letter_bits_next = letter_valid_next ? bits_reg : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= ST_IDLE;
            elem_cnt_reg     <= '0;
            bits_reg         <= '0;
            word_open_reg    <= 1'b0;
            busy_reg         <= 1'b0;
            letter_valid_reg <= 1'b0;
            letter_len_reg   <= '0;
            letter_bits_reg  <= '0;
            word_end_reg     <= 1'b0;
            err_reg          <= 1'b0;
        end else begin
            state_reg        <= state_next;
            elem_cnt_reg     <= elem_cnt_next;
            bits_reg         <= bits_next;
            word_open_reg    <= word_open_next;
            busy_reg         <= busy_next;
            letter_valid_reg <= letter_valid_next;
            letter_len_reg   <= letter_len_next;
            letter_bits_reg  <= letter_bits_next;
            word_end_reg     <= word_end_next;
            err_reg          <= err_next;
        end
    end

    assign bus.busy         = busy_reg;
    assign bus.letter_valid = letter_valid_reg;
    assign bus.letter_len   = letter_len_reg;
    assign bus.letter_bits  = letter_bits_reg;
    assign bus.word_end     = word_end_reg;
    assign bus.err          = err_reg;

endmodule

// File: tb/tb_morse_letter_ctrl.sv
// Scoreboard bench for morse_letter_ctrl: directed line patterns push expected
// pulses (with their cycle) and busy levels; a negedge monitor checks them.
module tb_morse_letter_ctrl;
    import morse_pkg::*;

    localparam int MAX_ELEM = 6;
    localparam logic [2:0] K_LV  = 3'b100;
    localparam logic [2:0] K_WE  = 3'b010;
    localparam logic [2:0] K_ERR = 3'b001;

    typedef struct {
        logic [2:0] kind;
        int         cyc;
        logic [2:0] len;
        logic [5:0] bits;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb[$];
    int   busy_exp[int];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    morse_letter_ctrl_if #(.MAX_ELEM(MAX_ELEM)) bus ();

    morse_letter_ctrl #(
        .MAX_ELEM(MAX_ELEM), .DASH_LEN(3), .LETTER_GAP(3), .WORD_GAP(7)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // eb: expected busy after this sample (2 = not checked); ek: expected pulse.
    task automatic send(input logic b, input int eb, input logic [2:0] ek = 3'b000,
                        input logic [2:0] el = 3'd0, input logic [5:0] ebits = 6'd0);
        exp_t e;
        @(negedge clk);
        bus.in = b;
        if (eb != 2) busy_exp[cyc + 1] = eb;
        if (ek != 3'b000) begin
            e.kind = ek; e.cyc = cyc + 1; e.len = el; e.bits = ebits;
            sb.push_back(e);
        end
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        logic [2:0] k;
        exp_t e;
        if (!rst) begin
            if (busy_exp.exists(cyc)) begin
                vectors++;
                if (bus.busy !== 1'(busy_exp[cyc])) begin
                    miscompares++;
                    $display("FAIL busy @cyc %0d: got %b expected %0d", cyc, bus.busy, busy_exp[cyc]);
                end
            end
            if (!bus.letter_valid) begin
                vectors++;
                if (bus.letter_len !== 3'd0 || bus.letter_bits !== 6'd0) begin
                    miscompares++;
                    $display("FAIL idle_letter @cyc %0d: len=%0d bits=%b expected 0", cyc,
                             bus.letter_len, bus.letter_bits);
                end
            end
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                e = sb.pop_front();
                vectors++;
                miscompares++;
                $display("FAIL missed_pulse: kind %b expected @cyc %0d, not seen", e.kind, e.cyc);
            end
            k = {bus.letter_valid, bus.word_end, bus.err};
            if (k != 3'b000) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_pulse @cyc %0d: kind %b, none expected", cyc, k);
                end else begin
                    e = sb.pop_front();
                    if (k !== e.kind || cyc != e.cyc ||
                        (bus.letter_valid && (bus.letter_len !== e.len || bus.letter_bits !== e.bits))) begin
                        miscompares++;
                        $display("FAIL pulse @cyc %0d: kind=%b len=%0d bits=%b, expected kind=%b @cyc %0d len=%0d bits=%b",
                                 cyc, k, bus.letter_len, bus.letter_bits, e.kind, e.cyc, e.len, e.bits);
                    end else begin
                        $display("pulse ok @cyc %0d kind=%b len=%0d bits=%b", cyc, k,
                                 bus.letter_len, bus.letter_bits);
                    end
                end
            end
        end
    end

    initial begin
        bus.in = 1'b0;
        rst    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {7'd0, bus.busy}, 8'd0);
        chk("rst_lv",   {7'd0, bus.letter_valid}, 8'd0);
        chk("rst_we",   {7'd0, bus.word_end}, 8'd0);
        chk("rst_err",  {7'd0, bus.err}, 8'd0);
        @(negedge clk);
        rst = 1'b0;

        // "A": dot, dash, letter gap
        send(1, 1); send(0, 1); send(1, 1); send(1, 1); send(1, 1); send(0, 1);
        send(0, 1); send(0, 0, K_LV, 3'd2, 6'b000010);

        // "E" then word gap, 8th zero silent
        send(1, 1); send(0, 1); send(0, 1); send(0, 0, K_LV, 3'd1, 6'b000000);
        send(0, 0); send(0, 0); send(0, 0); send(0, 0, K_WE); send(0, 0);

        // Bad two-unit mark, then clean "E"
        send(1, 1); send(1, 1); send(0, 0, K_ERR); send(0, 0); send(0, 0);
        send(1, 1); send(0, 1); send(0, 1); send(0, 0, K_LV, 3'd1, 6'b000000);

        // Long mark: err on 4th 1 only, recovery after three 0s
        send(1, 1); send(1, 1); send(1, 1); send(1, 0, K_ERR); send(1, 0); send(1, 0);
        send(0, 0); send(0, 0); send(0, 0);

        // "N" with a two-unit inter-element gap
        send(1, 1); send(1, 1); send(1, 1); send(0, 1); send(0, 1);
        send(1, 1); send(0, 1); send(0, 1); send(0, 0, K_LV, 3'd2, 6'b000001);

        // Full buffer: five dots and a dash
        for (int i = 0; i < 5; i++) begin
            send(1, 1); send(0, 1);
        end
        send(1, 1); send(1, 1); send(1, 1); send(0, 1); send(0, 1);
        send(0, 0, K_LV, 3'd6, 6'b100000);

        // Overflow: seventh dot errors; word_open survives ERR
        for (int i = 0; i < 6; i++) begin
            send(1, 1); send(0, 1);
        end
        send(1, 1); send(0, 0, K_ERR); send(0, 0); send(0, 0);
        send(0, 0); send(0, 0); send(0, 0); send(0, 0, K_WE); send(0, 0);

        // Async reset mid-dash
        send(1, 1); send(0, 1); send(1, 1); send(1, 2);
        @(posedge clk);
        #2;
        chk("pre_rst_busy", {7'd0, bus.busy}, 8'd1);
        rst = 1'b1;
        #1;
        chk("async_busy", {7'd0, bus.busy}, 8'd0);
        chk("async_lv",   {7'd0, bus.letter_valid}, 8'd0);
        chk("async_len",  {5'd0, bus.letter_len}, 8'd0);
        chk("async_bits", {2'd0, bus.letter_bits}, 8'd0);
        chk("async_we",   {7'd0, bus.word_end}, 8'd0);
        chk("async_err",  {7'd0, bus.err}, 8'd0);
        bus.in = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 7; i++) send(0, 0);

        repeat (4) @(negedge clk);
        chk("sb_drained", 8'(sb.size()), 8'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/morse_letter_ctrl.md
Name: morse_letter_ctrl

Overview:
Serial Morse front-end controller: samples one line bit per clock (1 clock = 1 Morse time unit), measures mark and space run lengths, and classifies each run as a dot, a dash, an element gap, a letter gap or a word gap.
It assembles elements into a letter buffer and emits a letter on a letter gap and a word_end pulse on a word gap.
It flags malformed marks and buffer overflow, then resynchronises.
It sits between the raw serial input and the character decoder, replacing the per-pattern detectors with one sequencer.

Parameters:
MAX_ELEM, 6, maximum elements per letter; sets the letter_bits width.
DASH_LEN, 3, mark length in units that is classified as a dash (a dot is always 1).
LETTER_GAP, 3, consecutive 0s that end a letter.
WORD_GAP, 7, consecutive 0s that end a word; must be greater than LETTER_GAP.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst  input  1  reset, asynchronous, active-high.
in  input  1  serial Morse line; 1 = mark, 0 = space; sampled every rising edge.
busy  output  1  a letter is in progress (state MARK or GAP).
letter_valid  output  1  one-cycle pulse: letter_len and letter_bits hold a completed letter.
letter_len  output  $clog2(MAX_ELEM+1)  number of elements in the letter, 1..MAX_ELEM.
letter_bits  output  MAX_ELEM  element i in bit i, first element in bit 0; 1 = dash, 0 = dot; unused bits are 0.
word_end  output  1  one-cycle pulse: word gap detected.
err  output  1  one-cycle pulse: malformed mark or overflow; the letter is discarded.

Behaviour:
- All outputs are registered.
- Reset (async, any time, including mid-letter): state IDLE; mark and space counters 0; element count 0; word_open 0; every output 0. No pulse follows reset release.
- Counters:
  - mark_cnt saturates at DASH_LEN+1.
  - space_cnt saturates at WORD_GAP.
  - Each counter clears when the opposite level is sampled.
- State IDLE (no letter open):
  - in=1: go to MARK, mark_cnt=1.
  - in=0: space_cnt++.
  - On the edge where space_cnt reaches WORD_GAP with word_open=1: word_end=1 for one cycle, word_open cleared.
  - Further 0s produce nothing.
- State MARK:
  - in=1: mark_cnt++. On the edge where mark_cnt would reach DASH_LEN+1: err pulse, go to ERR.
  - in=0 with mark_cnt==1: append dot. With mark_cnt==DASH_LEN: append dash. Any other value: err, go to ERR.
  - After an append: go to GAP, space_cnt=1.
  - Append when the element count already equals MAX_ELEM: err, go to ERR; the buffer is not modified.
- State GAP:
  - in=1 with space_cnt < LETTER_GAP: inter-element gap; go to MARK, mark_cnt=1. Gaps of 1..LETTER_GAP-1 units are accepted.
  - in=0: space_cnt++.
  - On the edge where space_cnt reaches LETTER_GAP:
    - letter_valid=1 for one cycle, with letter_len and letter_bits driven that cycle.
    - Buffer and element count cleared; word_open set; go to IDLE, keeping space_cnt.
- State ERR:
  - Buffer and element count cleared on entry.
  - Stay until LETTER_GAP consecutive 0s, then go to IDLE, keeping space_cnt. No letter_valid.
  - A 1 inside ERR restarts the 0 count.
  - word_open is unchanged.
- Latency: letter_valid and word_end assert in the cycle after the sampling edge of the terminating 0. err asserts in the cycle after the offending sample.
- letter_len and letter_bits are 0 whenever letter_valid=0.
- busy=1 in MARK and GAP; 0 in IDLE and ERR.
- letter_valid and word_end never assert in the same cycle, because WORD_GAP > LETTER_GAP.
- A leading space after reset never produces a word_end.

Decomposition:
- Package morse_pkg:
  - state enum {IDLE, MARK, GAP, ERR}.
  - Element encoding constants: ELEM_DOT=0, ELEM_DASH=1.
  - Default timing constants for DASH_LEN, LETTER_GAP and WORD_GAP.
- Sub-module morse_run_cnt: saturating run-length counter with clear-on-opposite-level and a configurable saturation value. Instantiated twice (mark, space).
- Controller FSM and letter buffer stay in morse_letter_ctrl.

Test Plan:
- "A": in = 1,0,1,1,1,0,0,0 after reset -> one letter_valid, letter_len=2, letter_bits=6'b000010, err=0; busy high from the first 1 until the letter ends.
- "E" then word gap: 1 followed by seven 0s -> letter_valid (len=1, bits=0) after the 3rd 0, word_end after the 7th 0, no further pulse on an 8th 0.
- Bad mark: 1,1,0,0,0 -> err pulse after the first 0, no letter_valid. Then 1,0,0,0 -> clean letter_valid, len=1.
- Long mark: four consecutive 1s -> err on the 4th 1, busy=0. Continued 1s do not re-pulse err; recovery only after three 0s.
- Overflow: seven dots separated by single 0s -> err on the 7th element, no letter_valid.
- Async reset asserted mid-dash after 1,0,1,1 -> all outputs 0 immediately. Then 0×7 -> no word_end and no letter_valid.
